// File: rtl/combat_pkg.sv
// Shared definitions for the combat resolver: player state codes, hit flag codes,
// the fight game-state code and the hitbox struct.
package combat_pkg;

    localparam int COORD_W = 10;

    typedef enum logic [3:0] {
        ST_IDLE           = 4'd0,
        ST_MOVEFORWARDS   = 4'd1,
        ST_MOVEBACKWARDS  = 4'd2,
        ST_B_ATTACK_START = 4'd3,
        ST_B_ATTACK_END   = 4'd4,
        ST_B_ATTACK_PULL  = 4'd5,
        ST_D_ATTACK_START = 4'd6,
        ST_D_ATTACK_END   = 4'd7,
        ST_D_ATTACK_PULL  = 4'd8,
        ST_HITSTUN        = 4'd9,
        ST_BLOCKSTUN      = 4'd10
    } pstate_t;

    typedef enum logic [1:0] {
        NOT_HIT   = 2'b00,
        HIT_BASIC = 2'b01,
        HIT_DIR   = 2'b10
    } hitflag_t;

    localparam logic [2:0] GS_FIGHT = 3'd2;

    typedef struct packed {
        logic [COORD_W-1:0] x1;
        logic [COORD_W-1:0] x2;
        logic [COORD_W-1:0] y1;
        logic [COORD_W-1:0] y2;
    } box_t;

endpackage

// File: rtl/combat_resolver_if.sv
// Bundle between the two player FSMs / game-state logic (master) and the
// combat resolver (slave).
interface combat_resolver_if;
    logic [2:0] gamestate;
    logic [3:0] p1_state, p2_state;
    logic [9:0] p1_basic_x1, p1_basic_x2, p1_basic_y1, p1_basic_y2;
    logic [9:0] p2_basic_x1, p2_basic_x2, p2_basic_y1, p2_basic_y2;
    logic [9:0] p1_dir_x1, p1_dir_x2, p1_dir_y1, p1_dir_y2;
    logic [9:0] p2_dir_x1, p2_dir_x2, p2_dir_y1, p2_dir_y2;
    logic [9:0] p1_hurt_x1, p1_hurt_x2, p1_hurt_y1, p1_hurt_y2;
    logic [9:0] p2_hurt_x1, p2_hurt_x2, p2_hurt_y1, p2_hurt_y2;
    logic [1:0] p1_hitflag, p2_hitflag;
    logic [2:0] p1_health, p2_health;
    logic [2:0] p1_block, p2_block;
    logic       p1_ko, p2_ko;

    modport master (
        output gamestate, p1_state, p2_state,
        output p1_basic_x1, p1_basic_x2, p1_basic_y1, p1_basic_y2,
        output p2_basic_x1, p2_basic_x2, p2_basic_y1, p2_basic_y2,
        output p1_dir_x1, p1_dir_x2, p1_dir_y1, p1_dir_y2,
        output p2_dir_x1, p2_dir_x2, p2_dir_y1, p2_dir_y2,
        output p1_hurt_x1, p1_hurt_x2, p1_hurt_y1, p1_hurt_y2,
        output p2_hurt_x1, p2_hurt_x2, p2_hurt_y1, p2_hurt_y2,
        input  p1_hitflag, p2_hitflag, p1_health, p2_health,
        input  p1_block, p2_block, p1_ko, p2_ko
    );

    modport slave (
        input  gamestate, p1_state, p2_state,
        input  p1_basic_x1, p1_basic_x2, p1_basic_y1, p1_basic_y2,
        input  p2_basic_x1, p2_basic_x2, p2_basic_y1, p2_basic_y2,
        input  p1_dir_x1, p1_dir_x2, p1_dir_y1, p1_dir_y2,
        input  p2_dir_x1, p2_dir_x2, p2_dir_y1, p2_dir_y2,
        input  p1_hurt_x1, p1_hurt_x2, p1_hurt_y1, p1_hurt_y2,
        input  p2_hurt_x1, p2_hurt_x2, p2_hurt_y1, p2_hurt_y2,
        output p1_hitflag, p2_hitflag, p1_health, p2_health,
        output p1_block, p2_block, p1_ko, p2_ko
    );
endinterface

// File: rtl/box_overlap.sv
// Inclusive axis-aligned overlap test between two boxes (unsigned coordinates).
module box_overlap
    import combat_pkg::*;
(
    input  box_t a,
    input  box_t b,
    output logic hit
);
    assign hit = (a.x1 <= b.x2) && (b.x1 <= a.x2) &&
                 (a.y1 <= b.y2) && (b.y1 <= a.y2);
endmodule

// File: rtl/combat_resolver.sv
// Resolves hits between the two players each cycle and keeps health, block
// meters and KO. Optional block-meter regeneration under `BLOCK_REGEN_EN.
module combat_resolver
    import combat_pkg::*;
#(
    parameter int MAX_HEALTH = 5,
    parameter int MAX_BLOCK  = 3,
    parameter int BASIC_DMG  = 1,
    parameter int DIR_DMG    = 2
`ifdef BLOCK_REGEN_EN
    , parameter int REGEN_TICKS = 120
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    combat_resolver_if.slave   cr
);
    // Index 0 is player 1, index 1 is player 2 throughout.
    logic [1:0][3:0] st;
    box_t [1:0]      basic, dir, hurt;

    assign st[0] = cr.p1_state;
    assign st[1] = cr.p2_state;
    assign basic[0] = '{x1: cr.p1_basic_x1, x2: cr.p1_basic_x2, y1: cr.p1_basic_y1, y2: cr.p1_basic_y2};
    assign basic[1] = '{x1: cr.p2_basic_x1, x2: cr.p2_basic_x2, y1: cr.p2_basic_y1, y2: cr.p2_basic_y2};
    assign dir[0]   = '{x1: cr.p1_dir_x1,   x2: cr.p1_dir_x2,   y1: cr.p1_dir_y1,   y2: cr.p1_dir_y2};
    assign dir[1]   = '{x1: cr.p2_dir_x1,   x2: cr.p2_dir_x2,   y1: cr.p2_dir_y1,   y2: cr.p2_dir_y2};
    assign hurt[0]  = '{x1: cr.p1_hurt_x1,  x2: cr.p1_hurt_x2,  y1: cr.p1_hurt_y1,  y2: cr.p1_hurt_y2};
    assign hurt[1]  = '{x1: cr.p2_hurt_x1,  x2: cr.p2_hurt_x2,  y1: cr.p2_hurt_y1,  y2: cr.p2_hurt_y2};

    logic [1:0][1:0] hitflag_q;
    logic [1:0][2:0] health_q, block_q;
    logic [1:0]      ko_q, landed_q;
    logic            fight;

    assign fight = (cr.gamestate == GS_FIGHT);

    // ov_*[g], atk_*[g], live[g] describe player g as attacker;
    // hit[g], blocked[g], *_nxt[g] describe player g as defender.
    logic [1:0]      ov_basic, ov_dir, atk_basic, atk_dir, live, vuln;
    logic [1:0]      hit, blocked, regen_step;
    logic [1:0][2:0] dmg, health_hit, health_nxt, block_nxt;

    for (genvar g = 0; g < 2; g++) begin : g_player
        localparam int A = 1 - g;

        box_overlap u_basic (.a(basic[g]), .b(hurt[A]), .hit(ov_basic[g]));
        box_overlap u_dir   (.a(dir[g]),   .b(hurt[A]), .hit(ov_dir[g]));

        assign atk_basic[g] = (st[g] == ST_B_ATTACK_END);
        assign atk_dir[g]   = (st[g] == ST_D_ATTACK_END);
        assign live[g]      = (atk_basic[g] | atk_dir[g]) & ~landed_q[g];
        assign vuln[g]      = (st[g] != ST_HITSTUN) && (st[g] != ST_BLOCKSTUN);

        assign hit[g] = live[A] & vuln[g] & ~(|ko_q) &
                        (atk_basic[A] ? ov_basic[A] : ov_dir[A]);
        assign blocked[g] = hit[g] && (st[g] == ST_MOVEBACKWARDS) && (block_q[g] != 3'd0);

        assign dmg[g]        = atk_basic[A] ? 3'(BASIC_DMG) : 3'(DIR_DMG);
        assign health_hit[g] = (health_q[g] > dmg[g]) ? health_q[g] - dmg[g] : 3'd0;
        assign health_nxt[g] = (hit[g] && !blocked[g]) ? health_hit[g] : health_q[g];

`ifdef BLOCK_REGEN_EN
        logic [15:0] regen_cnt;
        logic        regen_run;

        assign regen_run     = (block_q[g] < 3'(MAX_BLOCK)) && (st[g] != ST_BLOCKSTUN);
        assign regen_step[g] = regen_run && !blocked[g] && (regen_cnt == 16'(REGEN_TICKS - 1));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                   regen_cnt <= '0;
            else if (!fight || blocked[g]) regen_cnt <= '0;
            else if (regen_run)           regen_cnt <= regen_step[g] ? 16'd0 : regen_cnt + 16'd1;
        end
`else
        assign regen_step[g] = 1'b0;
`endif

        // A consume beats a regen step landing on the same edge.
        assign block_nxt[g] = blocked[g]    ? block_q[g] - 3'd1 :
                              regen_step[g] ? block_q[g] + 3'd1 : block_q[g];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                hitflag_q[i] <= NOT_HIT;
                health_q[i]  <= 3'(MAX_HEALTH);
                block_q[i]   <= 3'(MAX_BLOCK);
            end
            ko_q     <= '0;
            landed_q <= '0;
        end else if (!fight) begin
            for (int i = 0; i < 2; i++) begin
                hitflag_q[i] <= NOT_HIT;
                health_q[i]  <= 3'(MAX_HEALTH);
                block_q[i]   <= 3'(MAX_BLOCK);
            end
            ko_q     <= '0;
            landed_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                hitflag_q[i] <= hit[i] ? (atk_basic[1-i] ? HIT_BASIC : HIT_DIR) : NOT_HIT;
                health_q[i]  <= health_nxt[i];
                block_q[i]   <= block_nxt[i];
                ko_q[i]      <= (health_nxt[i] == 3'd0);
                // One hit per swing: held until the attacker leaves its END state.
                landed_q[i]  <= (atk_basic[i] | atk_dir[i]) & (landed_q[i] | hit[1-i]);
            end
        end
    end

    assign cr.p1_hitflag = hitflag_q[0];
    assign cr.p2_hitflag = hitflag_q[1];
    assign cr.p1_health  = health_q[0];
    assign cr.p2_health  = health_q[1];
    assign cr.p1_block   = block_q[0];
    assign cr.p2_block   = block_q[1];
    assign cr.p1_ko      = ko_q[0];
    assign cr.p2_ko      = ko_q[1];

endmodule

// File: tb/tb_combat_resolver.sv
// Directed bench for combat_resolver; regen scenarios only when BLOCK_REGEN_EN is defined.
module tb_combat_resolver;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    combat_resolver_if bus();

    combat_resolver #(
        .MAX_HEALTH(5), .MAX_BLOCK(3), .BASIC_DMG(1), .DIR_DMG(2)
`ifdef BLOCK_REGEN_EN
        , .REGEN_TICKS(4)
`endif
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .cr   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: sim time %0t exceeded budget", $time);
        $fatal(1, "timeout");
    end

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic init_inputs();
        bus.gamestate = 3'd2;
        bus.p1_state = 4'd0; bus.p2_state = 4'd0;
        bus.p1_hurt_x1 = 10'd0;   bus.p1_hurt_x2 = 10'd50;  bus.p1_hurt_y1 = 10'd100; bus.p1_hurt_y2 = 10'd200;
        bus.p2_hurt_x1 = 10'd100; bus.p2_hurt_x2 = 10'd150; bus.p2_hurt_y1 = 10'd100; bus.p2_hurt_y2 = 10'd200;
        bus.p1_basic_x1 = 10'd500; bus.p1_basic_x2 = 10'd510; bus.p1_basic_y1 = 10'd500; bus.p1_basic_y2 = 10'd510;
        bus.p2_basic_x1 = 10'd500; bus.p2_basic_x2 = 10'd510; bus.p2_basic_y1 = 10'd500; bus.p2_basic_y2 = 10'd510;
        bus.p1_dir_x1 = 10'd500; bus.p1_dir_x2 = 10'd510; bus.p1_dir_y1 = 10'd500; bus.p1_dir_y2 = 10'd510;
        bus.p2_dir_x1 = 10'd500; bus.p2_dir_x2 = 10'd510; bus.p2_dir_y1 = 10'd500; bus.p2_dir_y2 = 10'd510;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        init_inputs();
        repeat (2) step();
        n_cmp++; if ({bus.p1_health, bus.p2_health} !== {3'd5, 3'd5}) begin n_bad++;
            $display("FAIL reset_health: got %0d/%0d want 5/5", bus.p1_health, bus.p2_health); end
        n_cmp++; if ({bus.p1_block, bus.p2_block} !== {3'd3, 3'd3}) begin n_bad++;
            $display("FAIL reset_block: got %0d/%0d want 3/3", bus.p1_block, bus.p2_block); end
        n_cmp++; if ({bus.p1_hitflag, bus.p2_hitflag, bus.p1_ko, bus.p2_ko} !== 6'd0) begin n_bad++;
            $display("FAIL reset_flags: got %b%b ko %b%b want 0000 ko 00", bus.p1_hitflag, bus.p2_hitflag, bus.p1_ko, bus.p2_ko); end
        rst_n = 1'b1;
        repeat (3) step();
        n_cmp++; if ({bus.p1_health, bus.p2_health, bus.p1_block, bus.p2_block} !== {3'd5, 3'd5, 3'd3, 3'd3}) begin n_bad++;
            $display("FAIL idle_state: got h %0d/%0d b %0d/%0d want 5/5 3/3", bus.p1_health, bus.p2_health, bus.p1_block, bus.p2_block); end
        n_cmp++; if ({bus.p1_hitflag, bus.p2_hitflag, bus.p1_ko, bus.p2_ko} !== 6'd0) begin n_bad++;
            $display("FAIL idle_flags: got %b%b ko %b%b want 0", bus.p1_hitflag, bus.p2_hitflag, bus.p1_ko, bus.p2_ko); end
    endtask

    task automatic test_basic_hit();
        // One past the inclusive edge: no overlap.
        bus.p1_state = 4'd4;
        bus.p1_basic_x1 = 10'd151; bus.p1_basic_x2 = 10'd160; bus.p1_basic_y1 = 10'd150; bus.p1_basic_y2 = 10'd160;
        step();
        n_cmp++; if ({bus.p2_hitflag, bus.p2_health} !== {2'b00, 3'd5}) begin n_bad++;
            $display("FAIL edge_miss: got flag %b health %0d want 00 5", bus.p2_hitflag, bus.p2_health); end
        bus.p1_basic_x1 = 10'd150;
        step();
        n_cmp++; if (bus.p2_hitflag !== 2'b01) begin n_bad++;
            $display("FAIL basic_flag: got %b want 01", bus.p2_hitflag); end
        n_cmp++; if (bus.p2_health !== 3'd4) begin n_bad++;
            $display("FAIL basic_health: got %0d want 4", bus.p2_health); end
        n_cmp++; if (bus.p1_hitflag !== 2'b00) begin n_bad++;
            $display("FAIL basic_attacker_flag: got %b want 00", bus.p1_hitflag); end
        step();
        n_cmp++; if ({bus.p2_hitflag, bus.p2_health} !== {2'b00, 3'd4}) begin n_bad++;
            $display("FAIL basic_pulse: got flag %b health %0d want 00 4", bus.p2_hitflag, bus.p2_health); end
        step();
        n_cmp++; if (bus.p2_health !== 3'd4) begin n_bad++;
            $display("FAIL basic_single: got %0d want 4", bus.p2_health); end
        bus.p1_state = 4'd0;
        bus.p1_basic_x1 = 10'd500; bus.p1_basic_x2 = 10'd510; bus.p1_basic_y1 = 10'd500; bus.p1_basic_y2 = 10'd510;
        step();
    endtask

    task automatic test_blocked_dir();
        logic [2:0] exp_b, exp_h;
        bus.p1_state = 4'd2;
        bus.p2_dir_x1 = 10'd40; bus.p2_dir_x2 = 10'd50; bus.p2_dir_y1 = 10'd150; bus.p2_dir_y2 = 10'd160;
        for (int i = 0; i < 4; i++) begin
            bus.p2_state = 4'd7;
            step();
            exp_b = (i < 3) ? 3'(2 - i) : 3'd0;
            exp_h = (i < 3) ? 3'd5 : 3'd3;
            n_cmp++; if ({bus.p1_hitflag, bus.p1_block, bus.p1_health} !== {2'b10, exp_b, exp_h}) begin n_bad++;
                $display("FAIL block_swing%0d: got flag %b block %0d health %0d want 10 %0d %0d",
                         i, bus.p1_hitflag, bus.p1_block, bus.p1_health, exp_b, exp_h); end
            bus.p2_state = 4'd0;
            step();
        end
    endtask

    task automatic test_invuln_trade();
        bus.p1_state = 4'd9;
        bus.p2_state = 4'd7;
        step();
        n_cmp++; if ({bus.p1_hitflag, bus.p1_health} !== {2'b00, 3'd3}) begin n_bad++;
            $display("FAIL hitstun_immune: got flag %b health %0d want 00 3", bus.p1_hitflag, bus.p1_health); end
        bus.p2_state = 4'd0;
        step();
        bus.p1_state = 4'd4;
        bus.p1_basic_x1 = 10'd150; bus.p1_basic_x2 = 10'd160; bus.p1_basic_y1 = 10'd150; bus.p1_basic_y2 = 10'd160;
        bus.p2_state = 4'd7;
        step();
        n_cmp++; if ({bus.p2_hitflag, bus.p2_health} !== {2'b01, 3'd3}) begin n_bad++;
            $display("FAIL trade_p2: got flag %b health %0d want 01 3", bus.p2_hitflag, bus.p2_health); end
        n_cmp++; if ({bus.p1_hitflag, bus.p1_health} !== {2'b10, 3'd1}) begin n_bad++;
            $display("FAIL trade_p1: got flag %b health %0d want 10 1", bus.p1_hitflag, bus.p1_health); end
        bus.p1_state = 4'd0; bus.p2_state = 4'd0;
        step();
    endtask

    task automatic test_ko();
        bus.gamestate = 3'd0;
        step();
        n_cmp++; if ({bus.p1_health, bus.p2_health, bus.p1_block, bus.p2_block, bus.p1_ko, bus.p2_ko} !== {3'd5, 3'd5, 3'd3, 3'd3, 2'b00}) begin n_bad++;
            $display("FAIL round_setup: got h %0d/%0d b %0d/%0d ko %b%b want 5/5 3/3 00",
                     bus.p1_health, bus.p2_health, bus.p1_block, bus.p2_block, bus.p1_ko, bus.p2_ko); end
        bus.gamestate = 3'd2;
        step();
        for (int i = 0; i < 5; i++) begin
            bus.p1_state = 4'd4;
            step();
            n_cmp++; if ({bus.p2_health, bus.p2_ko} !== {3'(4 - i), (i == 4)}) begin n_bad++;
                $display("FAIL ko_swing%0d: got health %0d ko %b want %0d %b", i, bus.p2_health, bus.p2_ko, 4 - i, (i == 4)); end
            bus.p1_state = 4'd0;
            step();
        end
        bus.p2_state = 4'd7;
        step();
        n_cmp++; if ({bus.p1_hitflag, bus.p1_health, bus.p2_ko} !== {2'b00, 3'd5, 1'b1}) begin n_bad++;
            $display("FAIL ko_ignore: got flag %b health %0d p2_ko %b want 00 5 1", bus.p1_hitflag, bus.p1_health, bus.p2_ko); end
        bus.p2_state = 4'd0;
        bus.gamestate = 3'd0;
        step();
        n_cmp++; if ({bus.p2_health, bus.p2_block, bus.p2_ko} !== {3'd5, 3'd3, 1'b0}) begin n_bad++;
            $display("FAIL ko_restore: got health %0d block %0d ko %b want 5 3 0", bus.p2_health, bus.p2_block, bus.p2_ko); end
        bus.gamestate = 3'd2;
        step();
    endtask

`ifdef BLOCK_REGEN_EN
    task automatic test_regen();
        bus.p1_basic_x1 = 10'd500; bus.p1_basic_x2 = 10'd510;
        bus.p1_state = 4'd2; bus.p2_state = 4'd7;
        step();
        n_cmp++; if (bus.p1_block !== 3'd2) begin n_bad++;
            $display("FAIL regen_consume: got %0d want 2", bus.p1_block); end
        bus.p1_state = 4'd0; bus.p2_state = 4'd0;
        repeat (3) step();
        n_cmp++; if (bus.p1_block !== 3'd2) begin n_bad++;
            $display("FAIL regen_early: got %0d want 2", bus.p1_block); end
        step();
        n_cmp++; if (bus.p1_block !== 3'd3) begin n_bad++;
            $display("FAIL regen_step: got %0d want 3", bus.p1_block); end
        bus.p1_state = 4'd2; bus.p2_state = 4'd7;
        step();
        bus.p1_state = 4'd10; bus.p2_state = 4'd0;
        repeat (8) step();
        n_cmp++; if (bus.p1_block !== 3'd2) begin n_bad++;
            $display("FAIL regen_blockstun: got %0d want 2", bus.p1_block); end
        bus.p1_state = 4'd0;
        repeat (4) step();
        n_cmp++; if (bus.p1_block !== 3'd3) begin n_bad++;
            $display("FAIL regen_resume: got %0d want 3", bus.p1_block); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_hit();
        test_blocked_dir();
        test_invuln_trade();
        test_ko();
`ifdef BLOCK_REGEN_EN
        test_regen();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
